// File: rtl/dec_8b10b.sv
// 8b/10b symbol decoder with running-disparity tracking, error counting and
// comma-based link synchronisation; one symbol per cycle, one cycle latency.
module dec_8b10b #(
    parameter int ERR_LIMIT = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [9:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic             out_k,
    output logic             out_code_err,
    output logic             out_disp_err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             rd_pos,
    output logic             sync_ok,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int CW = $clog2(ERR_LIMIT + 1);

    typedef enum logic {
        ST_UNSYNC = 1'b0,
        ST_SYNC   = 1'b1
    } sync_state_e;

    function automatic logic [3:0] ones_cnt(input logic [9:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 10; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    logic [5:0]  six_s;
    logic [3:0]  four_s;
    logic [3:0]  fn_s;
    logic [4:0]  x_s;
    logic        v6_s;
    logic        k28_s;
    logic [2:0]  yd_s;
    logic        vd_s;
    logic        a7_s;
    logic [2:0]  yk_s;
    logic        vk_s;
    logic [2:0]  y_s;
    logic        is_k_s;
    logic        fmt_err_s;
    logic [3:0]  ones_s;
    logic        pos_s;
    logic        neg_s;
    logic        code_err_s;
    logic        disp_err_s;
    logic        errored_s;
    logic        comma_s;
    logic        xfer_s;

    logic              out_valid_q;
    logic [7:0]        out_data_q;
    logic              out_k_q;
    logic              out_code_err_q;
    logic              out_disp_err_q;
    logic              rd_q;
    logic              rd_d;
    sync_state_e       state_q;
    sync_state_e       state_d;
    logic [CW-1:0]     consec_q;
    logic [CW-1:0]     consec_d;
    logic [CNT_W-1:0]  err_cnt_q;
    logic [CNT_W-1:0]  err_cnt_d;

    assign six_s    = in_data[9:4];
    assign four_s   = in_data[3:0];
    // K28 in its RD+ form carries a complemented 4b sub-block
    assign fn_s     = (six_s == 6'b110000) ? ~four_s : four_s;
    assign in_ready = !out_valid_q || out_ready;
    assign xfer_s   = in_valid && in_ready;

    // 5b/6b lookup over both disparity columns
    always_comb begin
        x_s   = 5'd0;
        v6_s  = 1'b1;
        k28_s = 1'b0;
        case (six_s)
            6'b100111, 6'b011000: x_s = 5'd0;
            6'b011101, 6'b100010: x_s = 5'd1;
            6'b101101, 6'b010010: x_s = 5'd2;
            6'b110001:            x_s = 5'd3;
            6'b110101, 6'b001010: x_s = 5'd4;
            6'b101001:            x_s = 5'd5;
            6'b011001:            x_s = 5'd6;
            6'b111000, 6'b000111: x_s = 5'd7;
            6'b111001, 6'b000110: x_s = 5'd8;
            6'b100101:            x_s = 5'd9;
            6'b010101:            x_s = 5'd10;
            6'b110100:            x_s = 5'd11;
            6'b001101:            x_s = 5'd12;
            6'b101100:            x_s = 5'd13;
            6'b011100:            x_s = 5'd14;
            6'b010111, 6'b101000: x_s = 5'd15;
            6'b011011, 6'b100100: x_s = 5'd16;
            6'b100011:            x_s = 5'd17;
            6'b010011:            x_s = 5'd18;
            6'b110010:            x_s = 5'd19;
            6'b001011:            x_s = 5'd20;
            6'b101010:            x_s = 5'd21;
            6'b011010:            x_s = 5'd22;
            6'b111010, 6'b000101: x_s = 5'd23;
            6'b110011, 6'b001100: x_s = 5'd24;
            6'b100110:            x_s = 5'd25;
            6'b010110:            x_s = 5'd26;
            6'b110110, 6'b001001: x_s = 5'd27;
            6'b001110:            x_s = 5'd28;
            6'b101110, 6'b010001: x_s = 5'd29;
            6'b011110, 6'b100001: x_s = 5'd30;
            6'b101011, 6'b010100: x_s = 5'd31;
            6'b001111, 6'b110000: begin
                x_s   = 5'd28;
                k28_s = 1'b1;
            end
            default: v6_s = 1'b0;
        endcase
    end

    // 3b/4b lookup for data codes and for the normalised K28 sub-block
    always_comb begin
        yd_s = 3'd0;
        vd_s = 1'b1;
        a7_s = 1'b0;
        case (four_s)
            4'b1011, 4'b0100: yd_s = 3'd0;
            4'b1001:          yd_s = 3'd1;
            4'b0101:          yd_s = 3'd2;
            4'b1100, 4'b0011: yd_s = 3'd3;
            4'b1101, 4'b0010: yd_s = 3'd4;
            4'b1010:          yd_s = 3'd5;
            4'b0110:          yd_s = 3'd6;
            4'b1110, 4'b0001: yd_s = 3'd7;
            4'b0111, 4'b1000: begin
                yd_s = 3'd7;
                a7_s = 1'b1;
            end
            default: vd_s = 1'b0;
        endcase
        yk_s = 3'd0;
        vk_s = 1'b1;
        case (fn_s)
            4'b0100: yk_s = 3'd0;
            4'b1001: yk_s = 3'd1;
            4'b0101: yk_s = 3'd2;
            4'b0011: yk_s = 3'd3;
            4'b0010: yk_s = 3'd4;
            4'b1010: yk_s = 3'd5;
            4'b0110: yk_s = 3'd6;
            4'b1000: yk_s = 3'd7;
            default: vk_s = 1'b0;
        endcase
    end

    // Alternate-7 is data only after x=17/18/20 (0111) or x=11/13/14 (1000)
    always_comb begin
        is_k_s    = 1'b0;
        fmt_err_s = 1'b0;
        y_s       = yd_s;
        if (k28_s) begin
            is_k_s    = 1'b1;
            y_s       = yk_s;
            fmt_err_s = !vk_s;
        end else if (a7_s) begin
            case (x_s)
                5'd17, 5'd18, 5'd20: fmt_err_s = (four_s != 4'b0111);
                5'd11, 5'd13, 5'd14: fmt_err_s = (four_s != 4'b1000);
                5'd23, 5'd27, 5'd29, 5'd30: is_k_s = 1'b1;
                default: fmt_err_s = 1'b1;
            endcase
        end else begin
            fmt_err_s = !vd_s;
        end
    end

    assign ones_s     = ones_cnt(in_data);
    assign pos_s      = (ones_s == 4'd6);
    assign neg_s      = (ones_s == 4'd4);
    assign code_err_s = !v6_s || fmt_err_s || !(pos_s || neg_s || (ones_s == 4'd5));
    assign disp_err_s = !code_err_s && ((pos_s && rd_q) || (neg_s && !rd_q));
    assign errored_s  = code_err_s || disp_err_s;
    assign comma_s    = k28_s && !errored_s &&
                        ((y_s == 3'd1) || (y_s == 3'd5) || (y_s == 3'd7));

    // Running disparity, consecutive-error and total-error next state
    always_comb begin
        rd_d      = rd_q;
        consec_d  = consec_q;
        err_cnt_d = err_cnt_q;
        if (xfer_s) begin
            if (!code_err_s && pos_s) begin
                rd_d = 1'b1;
            end else if (!code_err_s && neg_s) begin
                rd_d = 1'b0;
            end else begin
                rd_d = rd_q;
            end
            if (errored_s) begin
                consec_d = (consec_q == CW'(ERR_LIMIT)) ? consec_q : consec_q + CW'(1);
                err_cnt_d = (err_cnt_q == {CNT_W{1'b1}}) ? err_cnt_q : err_cnt_q + CNT_W'(1);
            end else begin
                consec_d = '0;
            end
        end else begin
            rd_d = rd_q;
        end
    end

    // Sync FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_UNSYNC: begin
                if (xfer_s && comma_s) begin
                    state_d = ST_SYNC;
                end else begin
                    state_d = ST_UNSYNC;
                end
            end
            ST_SYNC: begin
                if (xfer_s && errored_s && (consec_d == CW'(ERR_LIMIT))) begin
                    state_d = ST_UNSYNC;
                end else begin
                    state_d = ST_SYNC;
                end
            end
            default: state_d = ST_UNSYNC;
        endcase
    end

    // Link state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q      <= 1'b0;
            state_q   <= ST_UNSYNC;
            consec_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            rd_q      <= rd_d;
            state_q   <= state_d;
            consec_q  <= consec_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Output stage: load on transfer, drop valid when consumed, else hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q    <= 1'b0;
            out_data_q     <= 8'h00;
            out_k_q        <= 1'b0;
            out_code_err_q <= 1'b0;
            out_disp_err_q <= 1'b0;
        end else if (xfer_s) begin
            out_valid_q    <= 1'b1;
            out_data_q     <= code_err_s ? 8'h00 : {y_s, x_s};
            out_k_q        <= is_k_s && !code_err_s;
            out_code_err_q <= code_err_s;
            out_disp_err_q <= disp_err_s;
        end else if (out_ready) begin
            out_valid_q    <= 1'b0;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_k        = out_k_q;
    assign out_code_err = out_code_err_q;
    assign out_disp_err = out_disp_err_q;
    assign rd_pos       = rd_q;
    assign sync_ok      = (state_q == ST_SYNC);
    assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_dec_8b10b.sv
// Directed bench for dec_8b10b: known Clause 36 symbols with hand-derived
// decoded bytes, disparity, sync and error-count expectations.
module tb_dec_8b10b;

    logic       clk;
    logic       rst;
    logic [9:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_k;
    logic       out_code_err;
    logic       out_disp_err;
    logic       out_valid;
    logic       out_ready;
    logic       rd_pos;
    logic       sync_ok;
    logic [3:0] err_cnt;

    int checks_cnt;
    int errors_cnt;

    dec_8b10b #(.ERR_LIMIT(4), .CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_k        (out_k),
        .out_code_err (out_code_err),
        .out_disp_err (out_disp_err),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .rd_pos       (rd_pos),
        .sync_ok      (sync_ok),
        .err_cnt      (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present one symbol; called #1 after a rising edge with out_ready=1
    task automatic send(input logic [9:0] sym);
        in_data  = sym;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] d, input logic k,
                           input logic ce, input logic de, input logic rd, input logic sy);
        chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".data"}, {24'd0, out_data}, {24'd0, d});
        chk({tag, ".k"}, {31'd0, out_k}, {31'd0, k});
        chk({tag, ".code_err"}, {31'd0, out_code_err}, {31'd0, ce});
        chk({tag, ".disp_err"}, {31'd0, out_disp_err}, {31'd0, de});
        chk({tag, ".rd"}, {31'd0, rd_pos}, {31'd0, rd});
        chk({tag, ".sync"}, {31'd0, sync_ok}, {31'd0, sy});
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #3;
        chk("rst.valid", {31'd0, out_valid}, 32'd0);
        chk("rst.data", {24'd0, out_data}, 32'd0);
        chk("rst.rd", {31'd0, rd_pos}, 32'd0);
        chk("rst.sync", {31'd0, sync_ok}, 32'd0);
        chk("rst.errcnt", {28'd0, err_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        in_data    = 10'h000;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        rst        = 1'b0;
        do_reset();

        send(10'h0FA); chk_out("k28_5m", 8'hBC, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        send(10'h305); chk_out("k28_5p", 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        send(10'h2AA); chk_out("d21_5", 8'hB5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("idle.valid", {31'd0, out_valid}, 32'd0);
        chk("idle.rd", {31'd0, rd_pos}, 32'd0);
        send(10'h0F8); chk_out("k28_7", 8'hFC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        send(10'h3A8); chk_out("k23_7", 8'hF7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        send(10'h237); chk_out("d17_7", 8'hF1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        send(10'h348); chk_out("d11_7", 8'hEB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send(10'h155); chk_out("d10_2", 8'h4A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send(10'h274); chk_out("d0_0", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send(10'h278); chk_out("badk", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("badk.errcnt", {28'd0, err_cnt}, 32'd1);
        send(10'h0FA); chk_out("resync", 8'hBC, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

        for (int i = 0; i < 4; i++) begin
            send(10'h3FF);
            chk_out("cerr", 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, (i < 3) ? 1'b1 : 1'b0);
        end
        chk("cerr.errcnt", {28'd0, err_cnt}, 32'd5);
        send(10'h305); chk_out("relock", 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Backpressure: held symbol must not be taken while output stalls
        send(10'h155);
        out_ready = 1'b0;
        in_data   = 10'h2AA;
        in_valid  = 1'b1;
        #1;
        chk("bp.in_ready0", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp.in_ready", {31'd0, in_ready}, 32'd0);
            chk_out("bp.hold", 8'h4A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp.release", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk_out("bp.next", 8'hB5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        do_reset();
        send(10'h0FA); chk_out("dd1", 8'hBC, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        send(10'h0FA); chk_out("dd2", 8'hBC, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("dd2.errcnt", {28'd0, err_cnt}, 32'd1);

        for (int i = 0; i < 16; i++) begin
            send(10'h3FF);
        end
        chk("sat.errcnt", {28'd0, err_cnt}, 32'd15);
        chk("sat.sync", {31'd0, sync_ok}, 32'd0);
        chk("sat.rd", {31'd0, rd_pos}, 32'd1);

        // Asynchronous reset with an output pending
        in_data  = 10'h2AA;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mid.pending", {31'd0, out_valid}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid.valid", {31'd0, out_valid}, 32'd0);
        chk("mid.data", {24'd0, out_data}, 32'd0);
        chk("mid.rd", {31'd0, rd_pos}, 32'd0);
        chk("mid.errcnt", {28'd0, err_cnt}, 32'd0);
        #2;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid.in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid.after", {31'd0, out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/dec_8b10b.md
DEC_8B10B -- requirements
Module: dec_8b10b

Interface
REQ-001 SHALL have parameter ERR_LIMIT, default 4, giving the number of consecutive errored symbols that drops sync.
REQ-002 SHALL have parameter CNT_W, default 16, giving the width of the error counter.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, asynchronous assertion, active-low.
REQ-005 in_data  input  10  received symbol; [9:4]=abcdei (a=bit9), [3:0]=fghj (j=bit0).
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  decoder accepts in_data this cycle.
REQ-008 out_data  output  8  decoded byte HGFEDCBA (A=bit0).
REQ-009 out_k  output  1  symbol is a valid control (K) code.
REQ-010 out_code_err  output  1  symbol is not in the 8b/10b code table.
REQ-011 out_disp_err  output  1  symbol violates running disparity.
REQ-012 out_valid  output  1  out_* fields valid.
REQ-013 out_ready  input  1  downstream accepts the output.
REQ-014 rd_pos  output  1  current running disparity; 1 = RD+, 0 = RD-.
REQ-015 sync_ok  output  1  link synchronised.
REQ-016 err_cnt  output  CNT_W  saturating count of errored symbols.

Function
REQ-017 Handshake: transfer on in_valid&&in_ready; in_ready = !out_valid || out_ready (combinational).
REQ-018 Latency: exactly 1 cycle from input transfer to out_valid=1 with the decoded fields; back-to-back throughput is 1 symbol/cycle.
REQ-019 out_valid SHALL clear on out_ready with no new transfer; out_* SHALL hold stable while out_valid && !out_ready.
REQ-020 Decoding: per IEEE 802.3 Clause 36 5b/6b and 3b/4b tables, both RD columns accepted for lookup.
REQ-021 K codes: K28.0-K28.7, K23.7, K27.7, K29.7, K30.7 only; any other K-form combination is a code error.
REQ-022 On code error: out_data=8'h00, out_k=0, out_code_err=1.
REQ-023 Symbol disparity: ones count 5 is neutral, 6 is +2, 4 is -2; any other count is a code error and leaves RD unchanged.
REQ-024 Disparity error: a +2 symbol received while RD+, or a -2 symbol received while RD-.
REQ-025 On disparity error: out_disp_err=1, data/K still decoded, RD forced to the symbol's ending sign (RD+ after +2, RD- after -2).
REQ-026 RD update for a legal symbol: toggles on +2/-2, holds on neutral.
REQ-027 RD SHALL update in the same cycle as the input transfer; rd_pos reflects the state after the last accepted symbol.
REQ-028 Errored symbol: code_err || disp_err. err_cnt SHALL increment by 1 per errored symbol and saturate at all-ones.
REQ-029 Sync FSM, state UNSYNC -> SYNC: on an accepted error-free K28.1, K28.5 or K28.7.
REQ-030 Sync FSM, state SYNC -> UNSYNC: on ERR_LIMIT consecutive errored symbols. A clean symbol clears the consecutive count; the count saturates at ERR_LIMIT.
REQ-031 sync_ok=1 iff state is SYNC; output data flows regardless of sync state.
REQ-032 With no input transfer, RD, FSM state and counters SHALL hold.

Reset
REQ-033 While rst=0, the following SHALL hold asynchronously: out_valid=0, out_data=0, out_k=0, out_code_err=0, out_disp_err=0, rd_pos=0 (RD-), sync_ok=0 (UNSYNC), err_cnt=0, consecutive-error count=0.
REQ-034 Reset mid-transfer SHALL discard the pending output; first cycle after release in_ready=1.

Verification
REQ-035 After reset, 10'h0FA (K28.5 RD-) -> next cycle out_data=8'hBC, out_k=1, no errors, rd_pos=1, sync_ok=1.
REQ-036 Then 10'h305 (K28.5 RD+) -> out_data=8'hBC, out_k=1, no errors, rd_pos=0.
REQ-037 At RD-, 10'h2AA (D21.5) -> out_data=8'hB5, out_k=0, no errors, rd_pos stays 0.
REQ-038 After reset, 10'h0FA twice -> second output out_disp_err=1, out_data=8'hBC, out_k=1, err_cnt=1, rd_pos=1.
REQ-039 In SYNC, 10'h3FF four times -> each out_code_err=1, out_data=8'h00, err_cnt=4, sync_ok=0 after the fourth; rd_pos unchanged.
REQ-040 Backpressure: out_valid=1 and out_ready=0 for 3 cycles -> in_ready=0 and out_* stable; then out_ready=1 -> the next symbol transfers and output updates 1 cycle later.
